// File: rtl/half_subtractor.sv
// Bit-wise half subtractor with combinational outputs and a one-cycle registered copy.
// Optional borrow-event counter enabled by defining HALF_SUB_STATS_EN.
module half_subtractor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
`ifdef HALF_SUB_STATS_EN
  output logic [CNT_W-1:0] borrow_cnt,
`endif
  output logic             out_valid
);

  if ((WIDTH < 1) || (WIDTH > 64) || (CNT_W < 1)) begin : g_bad_param
    $error("half_subtractor: WIDTH must be 1..64 and CNT_W at least 1");
  end

  always_comb begin
    diff   = a ^ b;
    borrow = ~a & b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      borrow_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q   <= diff;
        borrow_q <= borrow;
      end
    end
  end

`ifdef HALF_SUB_STATS_EN
  // Saturating: stop at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_cnt <= '0;
    end else if (in_valid && (|borrow) && (borrow_cnt != '1)) begin
      borrow_cnt <= borrow_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor: vector table, directed sequences and a random run
// checked against a lane-by-lane arithmetic reference model.
module tb_half_subtractor;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         in_valid;
  logic [W-1:0] diff, borrow, diff_q, borrow_q;
  logic         out_valid;
  logic [CW-1:0] borrow_cnt;
  logic         clk_run;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_dq, exp_bq;
  logic         exp_ov;
  int           exp_cnt;

  half_subtractor #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .diff      (diff),
    .borrow    (borrow),
    .diff_q    (diff_q),
    .borrow_q  (borrow_q),
`ifdef HALF_SUB_STATS_EN
    .borrow_cnt(borrow_cnt),
`endif
    .out_valid (out_valid)
  );

`ifndef HALF_SUB_STATS_EN
  assign borrow_cnt = '0;
`endif

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Reference: each lane is an independent 1-bit subtraction a - b.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      int d;
      d = int'(x[i]) - int'(y[i]);
      r[i] = ((d + 2) % 2) != 0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[i] = int'(x[i]) < int'(y[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".diff"},   64'(diff),   64'(ref_diff(a, b)));
    check({tag, ".borrow"}, 64'(borrow), 64'(ref_borrow(a, b)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".diff_q"},    64'(diff_q),    64'(exp_dq));
    check({tag, ".borrow_q"},  64'(borrow_q),  64'(exp_bq));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
`ifdef HALF_SUB_STATS_EN
    check({tag, ".borrow_cnt"}, 64'(borrow_cnt), 64'(exp_cnt));
`endif
  endtask

  task automatic model_reset();
    exp_dq  = '0;
    exp_bq  = '0;
    exp_ov  = 1'b0;
    exp_cnt = 0;
  endtask

  // Update the model from the inputs present before the edge, clock once, then compare.
  task automatic step(input string tag);
    exp_ov = in_valid;
    if (in_valid) begin
      exp_dq = ref_diff(a, b);
      exp_bq = ref_borrow(a, b);
      if ((ref_borrow(a, b) != '0) && (exp_cnt < CNT_MAX)) exp_cnt++;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vd;
    logic [W-1:0] vbo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    model_reset();

    vecs[0] = '{4'b0011, 4'b0101, 4'b0110, 4'b0100};
    vecs[1] = '{4'b1010, 4'b0110, 4'b1100, 4'b0100};
    vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
    vecs[4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    vecs[5] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};

    // No clock running and reset held: combinational path alone.
    #10;
    check_regs("reset_state");
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].va;
      b = vecs[i].vb;
      #100;
      check($sformatf("table%0d.diff", i),   64'(diff),   64'(vecs[i].vd));
      check($sformatf("table%0d.borrow", i), 64'(borrow), 64'(vecs[i].vbo));
    end
    check_regs("no_clock_regs");

    // Release reset away from any edge, then start the clock.
    a = '0; b = '0;
    #3 rst_n = 1'b1;
    #3 clk_run = 1'b1;
    @(posedge clk); #1;
    step("idle");

    // One-cycle latency, then hold with out_valid dropping.
    a = 4'b1010; b = 4'b0110; in_valid = 1'b1;
    step("lat1");
    check("lat1.diff_q_const",   64'(diff_q),   64'(4'b1100));
    check("lat1.borrow_q_const", 64'(borrow_q), 64'(4'b0100));
    in_valid = 1'b0;
    step("lat2");

    // Inputs toggle while in_valid=0: comb follows, registers hold.
    for (int i = 0; i < 4; i++) begin
      a = W'(i * 5 + 1);
      b = W'(i * 3 + 6);
      #1;
      check_comb($sformatf("hold%0d", i));
      step($sformatf("hold%0d", i));
    end

    // Async reset pulse between edges with a result in flight.
    a = 4'b0001; b = 4'b1110; in_valid = 1'b1;
    step("pre_rst");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    check_comb("async_rst");
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    step("post_rst");

    // Counter saturation: b>a on lane 0 for five valid cycles, then a no-borrow valid cycle.
    a = 4'b0000; b = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("sat%0d", i));
`ifdef HALF_SUB_STATS_EN
    check("sat.final_cnt", 64'(borrow_cnt), 64'(3));
`endif
    a = 4'b0001; b = 4'b0000;
    step("no_borrow");

    // Random run against the reference model.
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      check_comb("rnd");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
